// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, output record and helpers,
// used by the pixel scanner and the MiniAlu video path.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int   ADDR_W      = 24;
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [2:0] rgb;
  } pixel_out_t;

  localparam pixel_out_t PIXEL_IDLE = '{
    hsync:  ~SYNC_ACTIVE,
    vsync:  ~SYNC_ACTIVE,
    active: 1'b0,
    rgb:    3'b000
  };

  function automatic logic in_span(input int value, input int first, input int len);
    return (value >= first) && (value < first + len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..MAX on enabled edges and flags the wrap as a carry.
module vga_axis_counter #(
  parameter int MAX = 799,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX);

  assign wrap = enable && (count == LAST);

  // axis position register
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/vga_pixel_scanner.sv
// Raster scanner: walks the frame, fetches pixels from video memory and
// emits syncs/colour one pixel tick behind the counters.
module vga_pixel_scanner
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iPixelEnable,
  output logic [ADDR_W-1:0] oReadAddress,
  input  logic [2:0]        iPixelData,
  output logic              oHsync,
  output logic              oVsync,
  output logic              oRed,
  output logic              oGreen,
  output logic              oBlue,
  output logic              oActive,
  output logic              oFrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0]     hcount;
  logic [VW-1:0]     vcount;
  logic              h_wrap;
  logic              v_wrap;
  logic              visible;
  logic              in_hsync;
  logic              in_vsync;
  logic [ADDR_W-1:0] address;
  pixel_out_t        pix;
  pixel_out_t        pix_next;
  logic              frame_start;

  vga_axis_counter #(.MAX(H_TOTAL - 1)) u_hcount (
    .clock  (Clock),
    .reset  (Reset),
    .enable (iPixelEnable),
    .count  (hcount),
    .wrap   (h_wrap)
  );

  // the line carry steps the vertical axis, so both wrap on the same edge
  vga_axis_counter #(.MAX(V_TOTAL - 1)) u_vcount (
    .clock  (Clock),
    .reset  (Reset),
    .enable (h_wrap),
    .count  (vcount),
    .wrap   (v_wrap)
  );

  assign visible  = in_span(int'(hcount), 0, H_VISIBLE) && in_span(int'(vcount), 0, V_VISIBLE);
  assign in_hsync = in_span(int'(hcount), H_VISIBLE + H_FRONT, H_SYNC);
  assign in_vsync = in_span(int'(vcount), V_VISIBLE + V_FRONT, V_SYNC);

  // linear read address; parks at the end of the buffer through blanking
  always_ff @(posedge Clock) begin
    if (Reset) begin
      address <= '0;
    end else if (iPixelEnable) begin
      if (v_wrap) begin
        address <= '0;
      end else if (visible) begin
        address <= address + ADDR_W'(1);
      end else begin
        address <= address;
      end
    end else begin
      address <= address;
    end
  end

  assign oReadAddress = address;

  // next output pixel: memory data for the current position, blanked outside
  always_comb begin
    pix_next = pix;
    if (iPixelEnable) begin
      pix_next.active = visible;
      pix_next.hsync  = in_hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      pix_next.vsync  = in_vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      if (visible) begin
        pix_next.rgb = iPixelData;
      end else begin
        pix_next.rgb = 3'b000;
      end
    end else begin
      pix_next = pix;
    end
  end

  // output pixel register and one-clock frame marker
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pix         <= PIXEL_IDLE;
      frame_start <= 1'b0;
    end else begin
      pix         <= pix_next;
      frame_start <= v_wrap;
    end
  end

  assign oHsync      = pix.hsync;
  assign oVsync      = pix.vsync;
  assign oActive     = pix.active;
  assign oRed        = pix.rgb[2];
  assign oGreen      = pix.rgb[1];
  assign oBlue       = pix.rgb[0];
  assign oFrameStart = frame_start;

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Directed bench: full-size scanner for line timing and data path, a shrunken
// instance (16x11 raster) for whole-frame, blanking and reset behaviour.
module tb_vga_pixel_scanner;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, enable_a, hs_a, vs_a, r_a, g_a, b_a, act_a, fs_a;
  logic [23:0] addr_a;
  logic [2:0]  data_a;
  logic        reset_b, enable_b, hs_b, vs_b, r_b, g_b, b_b, act_b, fs_b;
  logic [23:0] addr_b;
  logic [2:0]  data_b;

  // memory models: A returns addr[2:0], B returns white everywhere
  assign data_a = addr_a[2:0];
  assign data_b = 3'b111;

  vga_pixel_scanner dut_a (
    .Clock(clock), .Reset(reset_a), .iPixelEnable(enable_a), .oReadAddress(addr_a),
    .iPixelData(data_a), .oHsync(hs_a), .oVsync(vs_a), .oRed(r_a), .oGreen(g_a),
    .oBlue(b_a), .oActive(act_a), .oFrameStart(fs_a)
  );

  vga_pixel_scanner #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .Clock(clock), .Reset(reset_b), .iPixelEnable(enable_b), .oReadAddress(addr_b),
    .iPixelData(data_b), .oHsync(hs_b), .oVsync(vs_b), .oRed(r_b), .oGreen(g_b),
    .oBlue(b_b), .oActive(act_b), .oFrameStart(fs_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // one clock: change enables on the falling edge, return just after the rising edge
  task automatic step(input logic en_a, input logic en_b);
    @(negedge clock);
    enable_a = en_a;
    enable_b = en_b;
    @(posedge clock);
    #1;
  endtask

  int hs_low1, hs_low2, first1, first2, vs_low_a;
  int hx, vy, nx, ny, exp_addr, pulses, last_pulse, vs_low_b;
  logic exp_act;

  initial begin
    reset_a = 1'b1; enable_a = 1'b1;
    reset_b = 1'b1; enable_b = 1'b0;

    // ---------------- full-size instance ----------------
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("a_rst_addr",  32'(addr_a), 0);
    check("a_rst_hsync", 32'(hs_a), 1);
    check("a_rst_vsync", 32'(vs_a), 1);
    check("a_rst_rgb",   32'({r_a, g_a, b_a}), 0);
    check("a_rst_active", 32'(act_a), 0);
    check("a_rst_frame", 32'(fs_a), 0);
    reset_a = 1'b0;

    hs_low1 = 0; hs_low2 = 0; first1 = 0; first2 = 0; vs_low_a = 0;
    for (int n = 1; n <= 1606; n++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      if (!hs_a) begin
        if (n <= 800) begin
          hs_low1++;
          if (first1 == 0) first1 = n;
        end else begin
          hs_low2++;
          if (first2 == 0) first2 = n;
        end
      end
      if (!vs_a) vs_low_a++;
      if (n == 640) begin
        check("a_addr_x640", 32'(addr_a), 640);
        check("a_active_x639", 32'(act_a), 1);
      end
      if (n == 641) begin
        check("a_active_x640", 32'(act_a), 0);
        check("a_rgb_x640", 32'({r_a, g_a, b_a}), 0);
      end
      if (n == 800) check("a_addr_line1", 32'(addr_a), 640);
      if (n == 1605) check("a_addr_x5y2", 32'(addr_a), 1285);
    end
    check("a_rgb_x5y2",    32'({r_a, g_a, b_a}), 5);
    check("a_active_x5y2", 32'(act_a), 1);
    check("a_hs_first1",   32'(first1), 657);
    check("a_hs_width1",   32'(hs_low1), 96);
    check("a_hs_first2",   32'(first2), 1457);
    check("a_hs_width2",   32'(hs_low2), 96);
    check("a_vs_idle",     32'(vs_low_a), 0);

    // hold the pixel enable low mid-line; nothing may move
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    check("a_frz_addr",   32'(addr_a), 1286);
    check("a_frz_rgb",    32'({r_a, g_a, b_a}), 5);
    check("a_frz_active", 32'(act_a), 1);
    check("a_frz_hsync",  32'(hs_a), 1);
    check("a_frz_frame",  32'(fs_a), 0);
    step(1'b1, 1'b0);
    check("a_resume_addr", 32'(addr_a), 1287);
    check("a_resume_rgb",  32'({r_a, g_a, b_a}), 6);

    // ---------------- shrunken instance: two whole frames ----------------
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    reset_b = 1'b0;
    hx = 0; vy = 0; pulses = 0; last_pulse = 0; vs_low_b = 0;
    for (int n = 1; n <= 352; n++) begin
      step(1'b0, 1'b1);
      exp_act = (hx < 8) && (vy < 6);
      check("b_active", 32'(act_b), 32'(exp_act));
      check("b_rgb",    32'({r_b, g_b, b_b}), exp_act ? 7 : 0);
      check("b_hsync",  32'(hs_b), (hx >= 10 && hx <= 12) ? 0 : 1);
      check("b_vsync",  32'(vs_b), (vy >= 7 && vy <= 8) ? 0 : 1);
      check("b_frame",  32'(fs_b), (hx == 15 && vy == 10) ? 1 : 0);
      if (fs_b) begin
        pulses++;
        check("b_frame_period", 32'(n - last_pulse), 176);
        last_pulse = n;
      end
      if (!vs_b) vs_low_b++;
      nx = (hx == 15) ? 0 : hx + 1;
      ny = (hx == 15) ? ((vy == 10) ? 0 : vy + 1) : vy;
      if (ny >= 6)     exp_addr = 48;
      else if (nx < 8) exp_addr = ny * 8 + nx;
      else             exp_addr = ny * 8 + 8;
      check("b_addr", 32'(addr_b), exp_addr);
      hx = nx; vy = ny;
      step(1'b0, 1'b0);
      check("b_frame_width", 32'(fs_b), 0);
    end
    check("b_pulses", 32'(pulses), 2);
    check("b_vs_ticks", 32'(vs_low_b), 64);

    // reset in the middle of a frame at (5,3), with the pixel enable high
    for (int n = 0; n < 53; n++) step(1'b0, 1'b1);
    check("b_pre_reset_addr", 32'(addr_b), 29);
    reset_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check("b_rst_frame", 32'(fs_b), 0);
    end
    check("b_rst_addr",   32'(addr_b), 0);
    check("b_rst_hsync",  32'(hs_b), 1);
    check("b_rst_vsync",  32'(vs_b), 1);
    check("b_rst_rgb",    32'({r_b, g_b, b_b}), 0);
    check("b_rst_active", 32'(act_b), 0);
    reset_b = 1'b0;
    step(1'b0, 1'b1);
    check("b_restart_addr",   32'(addr_b), 1);
    check("b_restart_active", 32'(act_b), 1);
    check("b_restart_rgb",    32'({r_b, g_b, b_b}), 7);
    check("b_restart_frame",  32'(fs_b), 0);
    step(1'b0, 1'b0);
    check("b_restart_frame2", 32'(fs_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
